// File: rtl/pipeline_pkg.sv
// Shared pipeline constants for the multiply/divide issue controller:
// instruction field codes, rstatus codes and the sequencer state encoding.
package pipeline_pkg;

  localparam logic [4:0] OPC_RTYPE = 5'b00000;
  localparam logic [4:0] ALU_MUL   = 5'b00110;
  localparam logic [4:0] ALU_DIV   = 5'b00111;

  localparam logic [31:0] RSTATUS_MUL_OVF  = 32'd4;
  localparam logic [31:0] RSTATUS_DIV_ZERO = 32'd5;

  typedef enum logic [1:0] {
    MD_IDLE  = 2'b00,
    MD_START = 2'b01,
    MD_WAIT  = 2'b10,
    MD_DONE  = 2'b11
  } md_state_e;

  function automatic logic is_md_op(input logic [4:0] opc, input logic [4:0] alu);
    return (opc == OPC_RTYPE) && ((alu == ALU_MUL) || (alu == ALU_DIV));
  endfunction

endpackage

// File: rtl/md_cycle_counter.sv
// Wait-cycle counter for the mul/div sequencer. tc flags the cycle whose
// increment brings the count to MAX_CYCLES, so the MAX_CYCLES-th wait cycle times out.
module md_cycle_counter #(
  parameter int MAX_CYCLES = 40,
  parameter int CNT_W      = 6
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] count_r;

  // Count register: clear wins over enable, otherwise hold.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (en) begin
      count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign tc = (count_r == CNT_W'(MAX_CYCLES - 1));

endmodule

// File: rtl/multdiv_sequencer.sv
// Issue/stall controller for the shared multi-cycle mul/div unit: freezes the
// front of the pipe, launches the unit, and hands result/status to X/M for one cycle.
module multdiv_sequencer
  import pipeline_pkg::*;
#(
  parameter int MAX_CYCLES = 40,
  parameter int CNT_W      = 6
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] dx_ir,
  input  logic [31:0] dx_a,
  input  logic [31:0] dx_b,
  input  logic        flush,
  input  logic        md_rdy,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  output logic        ctrl_mult,
  output logic        ctrl_div,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  output logic        stall,
  output logic        result_valid,
  output logic [31:0] result,
  output logic        exception,
  output logic [31:0] rstatus_code,
  output logic        busy
);

  md_state_e   state_r, state_s;
  logic        op_div_r;
  logic [31:0] md_a_r, md_b_r;
  logic [31:0] result_r, rstatus_code_r;
  logic        exception_r;

  logic        is_md_s, is_div_s;
  logic        stall_s, launch_s;
  logic        cnt_clr_s, cnt_en_s, cnt_tc_s;
  logic        cap_en_s, cap_exc_s;
  logic [31:0] cap_result_s, cap_code_s;
  logic        unused_ir_bits_s;

  assign is_md_s  = is_md_op(dx_ir[31:27], dx_ir[6:2]);
  assign is_div_s = (dx_ir[6:2] == ALU_DIV);
  // Instruction fields outside opcode/ALU op play no part in decode.
  assign unused_ir_bits_s = ^{dx_ir[26:7], dx_ir[1:0]};

  md_cycle_counter #(
    .MAX_CYCLES (MAX_CYCLES),
    .CNT_W      (CNT_W)
  ) u_wait_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (cnt_clr_s),
    .en      (cnt_en_s),
    .tc      (cnt_tc_s)
  );

  // Next-state, stall and capture decisions.
  always_comb begin
    state_s      = state_r;
    stall_s      = 1'b0;
    launch_s     = 1'b0;
    cnt_clr_s    = 1'b0;
    cnt_en_s     = 1'b0;
    cap_en_s     = 1'b0;
    cap_exc_s    = 1'b0;
    cap_result_s = 32'd0;
    cap_code_s   = 32'd0;
    case (state_r)
      MD_IDLE: begin
        if (is_md_s && !flush) begin
          stall_s = 1'b1;
          if (is_div_s && (dx_b == 32'd0)) begin
            state_s    = MD_DONE;
            cap_en_s   = 1'b1;
            cap_exc_s  = 1'b1;
            cap_code_s = RSTATUS_DIV_ZERO;
          end else begin
            state_s  = MD_START;
            launch_s = 1'b1;
          end
        end else begin
          state_s = MD_IDLE;
        end
      end
      MD_START: begin
        cnt_clr_s = 1'b1;
        if (flush) begin
          state_s = MD_IDLE;
        end else begin
          stall_s = 1'b1;
          state_s = MD_WAIT;
        end
      end
      MD_WAIT: begin
        if (flush) begin
          state_s = MD_IDLE;
        end else begin
          stall_s  = 1'b1;
          cnt_en_s = 1'b1;
          // A ready unit beats a timeout landing in the same cycle.
          if (md_rdy) begin
            state_s      = MD_DONE;
            cap_en_s     = 1'b1;
            cap_exc_s    = !op_div_r && md_exception;
            cap_result_s = cap_exc_s ? 32'd0 : md_result;
            cap_code_s   = cap_exc_s ? RSTATUS_MUL_OVF : 32'd0;
          end else if (cnt_tc_s) begin
            state_s    = MD_DONE;
            cap_en_s   = 1'b1;
            cap_exc_s  = 1'b1;
            cap_code_s = op_div_r ? RSTATUS_DIV_ZERO : RSTATUS_MUL_OVF;
          end else begin
            state_s = MD_WAIT;
          end
        end
      end
      MD_DONE: begin
        state_s = MD_IDLE;
      end
      default: begin
        state_s = MD_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= MD_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand and op latch at launch.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_div_r <= 1'b0;
      md_a_r   <= 32'd0;
      md_b_r   <= 32'd0;
    end else if (launch_s) begin
      op_div_r <= is_div_s;
      md_a_r   <= dx_a;
      md_b_r   <= dx_b;
    end else begin
      op_div_r <= op_div_r;
      md_a_r   <= md_a_r;
      md_b_r   <= md_b_r;
    end
  end

  // Result/status capture on entry to DONE; held until the next DONE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      result_r       <= 32'd0;
      exception_r    <= 1'b0;
      rstatus_code_r <= 32'd0;
    end else if (cap_en_s) begin
      result_r       <= cap_result_s;
      exception_r    <= cap_exc_s;
      rstatus_code_r <= cap_code_s;
    end else begin
      result_r       <= result_r;
      exception_r    <= exception_r;
      rstatus_code_r <= rstatus_code_r;
    end
  end

  // Stall is gated by reset so it falls without waiting for a clock.
  assign stall        = reset_n && stall_s;
  assign ctrl_mult    = (state_r == MD_START) && !op_div_r;
  assign ctrl_div     = (state_r == MD_START) && op_div_r;
  assign md_a         = md_a_r;
  assign md_b         = md_b_r;
  assign result_valid = (state_r == MD_DONE);
  assign result       = result_r;
  assign exception    = exception_r;
  assign rstatus_code = rstatus_code_r;
  assign busy         = (state_r != MD_IDLE);

endmodule
